blue_addr_gen: RTL and testbench
================================

BLUE_ADDR_GEN -- requirements
Module: blue_addr_gen

Interface
REQ-001 SHALL have parameter SPRITE_W, default 47, sprite width in pixels (row stride of the sprite ROM).
REQ-002 SHALL have parameter SPRITE_H, default 64, sprite height in pixels.
REQ-003 SHALL have port clk, input, 1, sole clock.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port pix_x, input, 10, current VGA column.
REQ-006 SHALL have port pix_y, input, 10, current VGA row.
REQ-007 SHALL have port pix_valid, input, 1, active-video flag for pix_x/pix_y.
REQ-008 SHALL have port pos_x, input, 10, sprite top-left column.
REQ-009 SHALL have port pos_y, input, 10, sprite top-left row.
REQ-010 SHALL have port key_left, input, 1, left-move request.
REQ-011 SHALL have port key_right, input, 1, right-move request.
REQ-012 SHALL have port on_ground, input, 1, 1 = character supported.
REQ-013 SHALL have port blue, output, 14, sprite ROM pixel address.
REQ-014 SHALL have port blue_state, output, 3, bit0 facing (0 left, 1 right); bit1 air (0 ground, 1 air); bit2 motion (0 stand, 1 move).
REQ-015 SHALL have port blue_hit, output, 1, 1 = current pixel lies inside the sprite box.

Function
REQ-016 SHALL define frame start as pix_valid=1, pix_x=0 and pix_y=0 in the same cycle.
REQ-017 SHALL latch pos_x/pos_y into internal registers at frame start only; position changes mid-frame are ignored until the next frame start.
REQ-018 SHALL update blue_state at frame start only, registered, visible on the cycle after frame start.
REQ-019 SHALL set facing=0 when key_left=1 and key_right=0; facing=1 when key_right=1 and key_left=0; otherwise hold.
REQ-020 SHALL set motion=1 iff exactly one of key_left/key_right is 1; both or neither -> 0.
REQ-021 SHALL set air = ~on_ground.
REQ-022 SHALL assert blue_hit, one cycle after the pixel, iff pix_valid=1, latched_x <= pix_x < latched_x+SPRITE_W and latched_y <= pix_y < latched_y+SPRITE_H.
REQ-023 SHALL perform the box comparison in 11-bit unsigned arithmetic so that latched_x+SPRITE_W > 1023 does not wrap; off-screen sprite parts are clipped.
REQ-024 SHALL drive blue = (pix_y-latched_y)*SPRITE_W + (pix_x-latched_x) when blue_hit=1, with latency 1 and aligned with blue_hit.
REQ-025 SHALL drive blue = 0 when blue_hit=0.
REQ-026 SHALL realise *SPRITE_W with shift-add or a row-base accumulator, not a generic multiplier; maximum address is SPRITE_W*SPRITE_H-1 (3007 at defaults).
REQ-027 SHALL use the pre-update blue_state and latched position for the frame-start pixel itself when frame start and key change coincide.
REQ-028 SHALL be a two-state FSM, IDLE (no frame seen since reset) and RUN: IDLE forces blue_hit=0 and blue=0; the first frame start moves to RUN.

Reset
REQ-029 SHALL, on rst_n=0 at a clk edge, set blue=0, blue_hit=0, blue_state=3'b001, latched position 0 and the FSM to IDLE.
REQ-030 SHALL, when reset occurs mid-frame, keep outputs at reset values until the next frame start after rst_n returns to 1.

Structure
REQ-031 SHALL source SPRITE_W/SPRITE_H defaults and the blue_state bit indices (FACING=0, AIR=1, MOTION=2) from the shared sprite package used by the sprite display blocks.
REQ-032 SHALL contain one sub-module, sprite_box_addr (box compare plus offset-to-address), reusable for other characters.

Verification
REQ-033 SHALL verify: with pos=(100,50) latched, pixel (100,50) -> blue=0, hit=1; pixel (146,113) -> blue=3007, hit=1; pixel (147,50) -> hit=0, blue=0.
REQ-034 SHALL verify: key_right=1 held across a frame start -> blue_state=3'b101; then both keys=1 at the next frame start -> 3'b001.
REQ-035 SHALL verify: key_left pulsed high for 10 cycles entirely mid-frame -> blue_state unchanged until the next frame start.
REQ-036 SHALL verify: pos_x=1000 latched, pixel (1023,0) with pos_y=0 -> hit=1, blue=23; no wrap aliasing at pix_x=0..6.
REQ-037 SHALL verify: on_ground=0 at frame start with key_left=1 -> blue_state=3'b110; pos change to (200,80) mid-frame -> pixel (200,80) hit=0 until the next frame.
REQ-038 SHALL verify: rst_n=0 for one cycle mid-frame -> blue=0, hit=0, state=3'b001, and hit stays 0 until the next frame start.

Source files
------------

// File: rtl/blue_addr_gen_pkg.sv
// Shared sprite package: sprite geometry defaults, blue_state bit layout and
// the move/facing update rule used by the sprite display blocks.
package blue_addr_gen_pkg;

  localparam int SPRITE_W_DEF = 47;
  localparam int SPRITE_H_DEF = 64;

  localparam int COORD_W = 10;
  localparam int ADDR_W  = 14;

  // blue_state bit indices
  localparam int FACING = 0;
  localparam int AIR    = 1;
  localparam int MOTION = 2;

  // Facing right, on the ground, standing still.
  localparam logic [2:0] STATE_RST = 3'b001;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } fsm_t;

  // Character state for the coming frame, sampled from the controls.
  function automatic logic [2:0] next_blue_state(input logic [2:0] cur,
                                                 input logic       key_left,
                                                 input logic       key_right,
                                                 input logic       on_ground);
    logic [2:0] nxt;
    nxt = cur;
    if (key_left && !key_right)      nxt[FACING] = 1'b0;
    else if (key_right && !key_left) nxt[FACING] = 1'b1;
    nxt[AIR]    = ~on_ground;
    nxt[MOTION] = key_left ^ key_right;
    return nxt;
  endfunction

endpackage

// File: rtl/blue_addr_gen_if.sv
// Pixel-scan / control inputs and sprite ROM address outputs of the
// blue character address generator.
interface blue_addr_gen_if;
  import blue_addr_gen_pkg::*;

  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               pix_valid;
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic               key_left;
  logic               key_right;
  logic               on_ground;
  logic [ADDR_W-1:0]  blue;
  logic [2:0]         blue_state;
  logic               blue_hit;

  modport master (
    output pix_x, pix_y, pix_valid, pos_x, pos_y, key_left, key_right, on_ground,
    input  blue, blue_state, blue_hit
  );

  modport slave (
    input  pix_x, pix_y, pix_valid, pos_x, pos_y, key_left, key_right, on_ground,
    output blue, blue_state, blue_hit
  );
endinterface

// File: rtl/blue_addr_gen_sprite_box_addr.sv
// Combinational sprite box test plus pixel-offset to ROM address conversion.
// Reusable for any character sprite with a fixed row stride.
module sprite_box_addr
  import blue_addr_gen_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_W_DEF,
  parameter int SPRITE_H = SPRITE_H_DEF
) (
  input  logic [COORD_W-1:0] pix_x_i,
  input  logic [COORD_W-1:0] pix_y_i,
  input  logic               pix_valid_i,
  input  logic [COORD_W-1:0] org_x_i,
  input  logic [COORD_W-1:0] org_y_i,
  output logic               hit_o,
  output logic [ADDR_W-1:0]  addr_o
);

  localparam logic [COORD_W:0] W_EXT = (COORD_W+1)'(SPRITE_W);
  localparam logic [COORD_W:0] H_EXT = (COORD_W+1)'(SPRITE_H);

  // One extra bit so a box hanging off the right/bottom edge clips instead of
  // wrapping around to column/row 0.
  logic [COORD_W:0]   px, py, ox, oy;
  logic               in_x, in_y;
  logic [COORD_W-1:0] dx, dy;
  logic [ADDR_W-1:0]  row_base;

  assign px = {1'b0, pix_x_i};
  assign py = {1'b0, pix_y_i};
  assign ox = {1'b0, org_x_i};
  assign oy = {1'b0, org_y_i};

  assign in_x  = (px >= ox) && (px < ox + W_EXT);
  assign in_y  = (py >= oy) && (py < oy + H_EXT);
  assign hit_o = pix_valid_i && in_x && in_y;

  // Offsets are only meaningful inside the box, where they never underflow.
  assign dx = pix_x_i - org_x_i;
  assign dy = pix_y_i - org_y_i;

  // Row base dy*SPRITE_W as a sum of shifted copies of dy, one per set bit of
  // the constant stride.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    row_base = '0;
    for (int b = 0; b <= COORD_W; b++) begin
      if (W_EXT[b]) row_base = row_base + (ADDR_W'({4'd0, dy}) << b);
    end
  end

  assign addr_o = row_base + {4'd0, dx};

endmodule

// File: rtl/blue_addr_gen.sv
// Blue character sprite address generator: latches position and character
// state once per frame and maps each scanned pixel to a sprite ROM address.
module blue_addr_gen
  import blue_addr_gen_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_W_DEF,
  parameter int SPRITE_H = SPRITE_H_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  blue_addr_gen_if.slave  bus
);

  fsm_t               fsm_q, fsm_d;
  logic [COORD_W-1:0] lat_x_q, lat_x_d;
  logic [COORD_W-1:0] lat_y_q, lat_y_d;
  logic [2:0]         state_q, state_d;
  logic               hit_q, hit_d;
  logic [ADDR_W-1:0]  blue_q, blue_d;

  logic               frame_start;
  logic               box_hit;
  logic [ADDR_W-1:0]  box_addr;

  assign frame_start = bus.pix_valid && (bus.pix_x == '0) && (bus.pix_y == '0);

  // The box test uses the registered position, so the frame-start pixel still
  // sees the previous frame's position.
  sprite_box_addr #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_box (
    .pix_x_i     (bus.pix_x),
    .pix_y_i     (bus.pix_y),
    .pix_valid_i (bus.pix_valid),
    .org_x_i     (lat_x_q),
    .org_y_i     (lat_y_q),
    .hit_o       (box_hit),
    .addr_o      (box_addr)
  );

  // Next state: frame-start sampling of position/controls, and pixel outputs.
  always_comb begin
    fsm_d   = fsm_q;
    lat_x_d = lat_x_q;
    lat_y_d = lat_y_q;
    state_d = state_q;
    if (frame_start) begin
      fsm_d   = ST_RUN;
      lat_x_d = bus.pos_x;
      lat_y_d = bus.pos_y;
      state_d = next_blue_state(state_q, bus.key_left, bus.key_right, bus.on_ground);
    end
    hit_d  = (fsm_q == ST_RUN) && box_hit;
    blue_d = hit_d ? box_addr : '0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      lat_x_q <= '0;
      lat_y_q <= '0;
      state_q <= STATE_RST;
      hit_q   <= 1'b0;
      blue_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      lat_x_q <= lat_x_d;
      lat_y_q <= lat_y_d;
      state_q <= state_d;
      hit_q   <= hit_d;
      blue_q  <= blue_d;
    end
  end

  assign bus.blue       = blue_q;
  assign bus.blue_hit   = hit_q;
  assign bus.blue_state = state_q;

endmodule

// File: tb/tb_blue_addr_gen.sv
// Directed bench for blue_addr_gen: a reference model pushes the expected
// pixel result per driven pixel and the registered DUT output is popped and
// compared one cycle later.
module tb_blue_addr_gen;

  localparam int W = 47;
  localparam int H = 64;

  typedef struct {
    logic        hit;
    logic [13:0] blue;
    logic [2:0]  state;
  } exp_t;

  logic clk;
  logic rst_n;

  blue_addr_gen_if bif();

  blue_addr_gen #(
    .SPRITE_W (W),
    .SPRITE_H (H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_cmp = 0;
  int   n_mis = 0;
  exp_t sb_q[$];

  // Reference model state
  bit       mdl_run;
  int       mdl_lx, mdl_ly;
  bit       mdl_face;
  bit [2:0] mdl_state;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one pixel at the falling edge, predict the result, then compare the
  // registered outputs just after the next rising edge.
  task automatic step(input int x, input int y, input bit v, input string tag);
    exp_t e;
    exp_t got;
    int   xi, yi;
    bit   fs;
    @(negedge clk);
    bif.pix_x     = 10'(x);
    bif.pix_y     = 10'(y);
    bif.pix_valid = v;
    xi = x;
    yi = y;
    if (!rst_n) begin
      mdl_run   = 0;
      mdl_lx    = 0;
      mdl_ly    = 0;
      mdl_face  = 1;
      mdl_state = 3'b001;
      e.hit     = 1'b0;
      e.blue    = '0;
    end else begin
      e.hit  = mdl_run && v && xi >= mdl_lx && xi < mdl_lx + W && yi >= mdl_ly && yi < mdl_ly + H;
      e.blue = e.hit ? 14'((yi - mdl_ly) * W + (xi - mdl_lx)) : 14'd0;
      fs = v && xi == 0 && yi == 0;
      if (fs) begin
        mdl_run = 1;
        mdl_lx  = int'(bif.pos_x);
        mdl_ly  = int'(bif.pos_y);
        if (bif.key_left && !bif.key_right) mdl_face = 0;
        if (bif.key_right && !bif.key_left) mdl_face = 1;
        mdl_state = {bit'(bif.key_left != bif.key_right), bit'(!bif.on_ground), mdl_face};
      end
    end
    e.state = mdl_state;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end else begin
      got = sb_q.pop_front();
      check({tag, ".hit"},   16'(bif.blue_hit),   16'(got.hit));
      check({tag, ".blue"},  16'(bif.blue),       16'(got.blue));
      check({tag, ".state"}, 16'(bif.blue_state), 16'(got.state));
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bif.pix_x     = '0;
    bif.pix_y     = '0;
    bif.pix_valid = 1'b0;
    bif.pos_x     = 10'd100;
    bif.pos_y     = 10'd50;
    bif.key_left  = 1'b0;
    bif.key_right = 1'b0;
    bif.on_ground = 1'b1;

    // Reset, then IDLE: scanning is ignored before the first frame start.
    step(5, 5, 1, "reset0");
    step(100, 50, 1, "reset1");
    rst_n = 1'b1;
    step(100, 50, 1, "idle_px");

    // First frame start latches (100,50); box corners and edges.
    step(0, 0, 1, "fs1");
    step(100, 50, 1, "corner_tl");
    step(146, 113, 1, "corner_br");
    step(147, 50, 1, "right_out");
    step(99, 50, 1, "left_out");
    step(100, 49, 1, "top_out");
    step(146, 114, 1, "bottom_out");
    step(120, 60, 0, "not_valid");
    step(123, 77, 1, "inside");

    // Right held over a frame start, then both keys.
    bif.key_right = 1'b1;
    step(0, 0, 1, "fs_right");
    step(110, 51, 1, "after_right");
    bif.key_left = 1'b1;
    step(0, 0, 1, "fs_both");
    step(5, 5, 1, "after_both");

    // Left pulse entirely mid-frame must not touch the state.
    bif.key_left  = 1'b0;
    bif.key_right = 1'b0;
    step(0, 0, 1, "fs_idlekeys");
    bif.key_left = 1'b1;
    for (int i = 0; i < 10; i++) step(101 + i, 52, 1, "mid_left");
    bif.key_left = 1'b0;
    step(0, 0, 1, "fs_after_pulse");

    // Sprite at the right screen edge: clipped, no wrap to column 0.
    bif.pos_x = 10'd1000;
    bif.pos_y = 10'd0;
    step(0, 0, 1, "fs_edge");
    step(1023, 0, 1, "edge_1023");
    step(0, 1, 1, "wrap_x0");
    for (int x = 1; x <= 6; x++) step(x, 0, 1, "wrap_x");
    step(1000, 63, 1, "edge_bl");
    step(1000, 64, 1, "edge_below");

    // Airborne, moving left; position change mid-frame ignored.
    bif.on_ground = 1'b0;
    bif.key_left  = 1'b1;
    step(0, 0, 1, "fs_air_left");
    bif.pos_x = 10'd200;
    bif.pos_y = 10'd80;
    step(200, 80, 1, "pos_mid");
    step(0, 0, 1, "fs_newpos");
    step(200, 80, 1, "pos_new");
    step(246, 143, 1, "pos_new_br");

    // One-cycle reset mid-frame: outputs idle until the next frame start.
    bif.on_ground = 1'b1;
    bif.key_left  = 1'b0;
    rst_n = 1'b0;
    step(210, 90, 1, "mid_reset");
    rst_n = 1'b1;
    step(200, 80, 1, "post_reset0");
    step(201, 81, 1, "post_reset1");
    step(0, 0, 1, "fs_post_reset");
    step(201, 81, 1, "post_reset_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
